// File: rtl/poseidon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poseidon_pkg
// Brief    : Shared field constants, element type and framer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package poseidon_pkg;

    localparam int C_FIELD_W = 255;
    localparam int C_ARITY   = 3;

    localparam logic [255:0] C_MODULUS_256 =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam logic [C_FIELD_W-1:0] C_MODULUS = C_MODULUS_256[C_FIELD_W-1:0];

    typedef logic [C_FIELD_W-1:0] field_elem_t;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        PAD  = 1'b1
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/poseidon_field_reduce.sv
`default_nettype none
// ============================================================================
// Module   : poseidon_field_reduce
// Brief    : Combinational single-step reduction of a 255-bit word into the field.
// Revision : 1.0 - initial release
// ============================================================================
module poseidon_field_reduce
    import poseidon_pkg::*;
#(
    parameter field_elem_t MODULUS = C_MODULUS
) (
    input  field_elem_t i_x,
    output field_elem_t o_y,
    output logic        o_reduced
);

    // 2^255 < 2*MODULUS, so a single conditional subtraction lands in range.
    assign o_reduced = (i_x >= MODULUS);
    assign o_y       = o_reduced ? (i_x - MODULUS) : i_x;

endmodule
`default_nettype wire

// File: rtl/poseidon_input_framer.sv
`default_nettype none
// ============================================================================
// Module   : poseidon_input_framer
// Brief    : Reduces host words into the field, frames them into ARITY-element
//            groups with zero padding, and counts frames handed to the hasher.
// Revision : 1.0 - initial release
// ============================================================================
module poseidon_input_framer
    import poseidon_pkg::*;
#(
    parameter int          ARITY      = C_ARITY,
    parameter int          NUM_FRAMES = 100,
    parameter field_elem_t MODULUS    = C_MODULUS,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 io_input_valid,
    output logic                 io_input_ready,
    input  logic                 io_input_last,
    input  logic [255:0]         io_input_payload,
    output logic                 io_output_valid,
    input  logic                 io_output_ready,
    output logic                 io_output_last,
    output logic [C_FIELD_W-1:0] io_output_payload,
    output logic [CNT_W-1:0]     frames_out,
    output logic [CNT_W-1:0]     reduced_cnt,
    output logic                 done
);

    localparam int               IDX_W        = (ARITY > 1) ? $clog2(ARITY) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(ARITY - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_NUM_FRAMES = CNT_W'(NUM_FRAMES);

    frame_state_t     r_state;
    logic [IDX_W-1:0] r_elem_idx;
    logic             r_valid;
    logic             r_last;
    field_elem_t      r_payload;
    logic [CNT_W-1:0] r_frames;
    logic [CNT_W-1:0] r_reduced_cnt;
    logic             r_done;

    field_elem_t      w_reduced_val;
    logic             w_needs_sub;
    logic             w_ld;
    logic             w_in_hs;
    logic             w_pad_ld;
    logic             w_load;
    logic             w_at_last;
    logic             w_frame_hs;
    logic             w_unused_msb;

    poseidon_field_reduce #(
        .MODULUS (MODULUS)
    ) u_reduce (
        .i_x       (io_input_payload[C_FIELD_W-1:0]),
        .o_y       (w_reduced_val),
        .o_reduced (w_needs_sub)
    );

    assign w_unused_msb   = io_input_payload[255];

    assign w_ld           = !r_valid || io_output_ready;
    assign io_input_ready = (r_state == PASS) && w_ld && !r_done;
    assign w_in_hs        = io_input_valid && io_input_ready;
    assign w_pad_ld       = (r_state == PAD) && w_ld;
    assign w_load         = w_in_hs || w_pad_ld;
    assign w_at_last      = (r_elem_idx == C_LAST_IDX);
    assign w_frame_hs     = r_valid && io_output_ready && r_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= PASS;
            r_elem_idx    <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_payload     <= '0;
            r_frames      <= '0;
            r_reduced_cnt <= '0;
            r_done        <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_last     <= w_at_last;
                r_payload  <= w_in_hs ? w_reduced_val : '0;
                r_elem_idx <= w_at_last ? '0 : r_elem_idx + IDX_W'(1);
            end else if (w_ld) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            // A last word only pads out the frame it lands in.
            case (r_state)
                PASS: begin
                    if (w_in_hs && io_input_last && !w_at_last) begin
                        r_state <= PAD;
                    end
                end
                PAD: begin
                    if (w_ld && w_at_last) begin
                        r_state <= PASS;
                    end
                end
                default: r_state <= PASS;
            endcase

            if (w_in_hs && w_needs_sub && (r_reduced_cnt != C_CNT_MAX)) begin
                r_reduced_cnt <= r_reduced_cnt + CNT_W'(1);
            end

            if (w_frame_hs && (r_frames != C_CNT_MAX)) begin
                r_frames <= r_frames + CNT_W'(1);
                if ((r_frames + CNT_W'(1)) == C_NUM_FRAMES) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign io_output_valid   = r_valid;
    assign io_output_last    = r_last;
    assign io_output_payload = r_payload;
    assign frames_out        = r_frames;
    assign reduced_cnt       = r_reduced_cnt;
    assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_poseidon_input_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_poseidon_input_framer
// Brief    : Directed self-checking bench with an expected-output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poseidon_input_framer;

    localparam int ARITY      = 3;
    localparam int NUM_FRAMES = 100;
    localparam int CNT_W      = 16;
    localparam logic [255:0] MOD =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             io_input_valid = 1'b0;
    logic             io_input_ready;
    logic             io_input_last = 1'b0;
    logic [255:0]     io_input_payload = '0;
    logic             io_output_valid;
    logic             io_output_ready = 1'b1;
    logic             io_output_last;
    logic [254:0]     io_output_payload;
    logic [CNT_W-1:0] frames_out;
    logic [CNT_W-1:0] reduced_cnt;
    logic             done;

    always #5 clk = ~clk;

    poseidon_input_framer #(
        .ARITY      (ARITY),
        .NUM_FRAMES (NUM_FRAMES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .io_input_valid    (io_input_valid),
        .io_input_ready    (io_input_ready),
        .io_input_last     (io_input_last),
        .io_input_payload  (io_input_payload),
        .io_output_valid   (io_output_valid),
        .io_output_ready   (io_output_ready),
        .io_output_last    (io_output_last),
        .io_output_payload (io_output_payload),
        .frames_out        (frames_out),
        .reduced_cnt       (reduced_cnt),
        .done              (done)
    );

    typedef struct {
        logic [254:0] p;
        logic         l;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           model_idx = 0;
    bit           in_hs_seen = 0;
    bit           prev_stall = 0;
    logic [254:0] held_p = '0;
    logic         held_l = 1'b0;
    bit           stall_mode = 0;
    int           cyc = 0;
    logic [3:0]   stall_pat = 4'b1001;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [255:0] w, input logic last);
        exp_t         e;
        logic [255:0] r;
        r   = {1'b0, w[254:0]} % MOD;
        e.p = r[254:0];
        e.l = (model_idx == ARITY - 1);
        sb.push_back(e);
        if (last && model_idx < ARITY - 1) begin
            for (int k = model_idx + 1; k < ARITY; k++) begin
                e.p = '0;
                e.l = (k == ARITY - 1);
                sb.push_back(e);
            end
            model_idx = 0;
        end else begin
            model_idx = (model_idx == ARITY - 1) ? 0 : model_idx + 1;
        end
    endtask

    // Runs at the falling edge: values here are what the next rising edge sees.
    task automatic monitor();
        exp_t e;
        in_hs_seen = 0;
        if (prev_stall) begin
            chk("hold_valid", 256'(io_output_valid), 256'd1);
            chk("hold_payload", 256'(io_output_payload), 256'(held_p));
            chk("hold_last", 256'(io_output_last), 256'(held_l));
        end
        if (io_output_valid && io_output_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 256'(io_output_valid), 256'd0);
            end else begin
                e = sb.pop_front();
                chk("out_payload", 256'(io_output_payload), 256'(e.p));
                chk("out_last", 256'(io_output_last), 256'(e.l));
            end
        end
        prev_stall = io_output_valid && !io_output_ready;
        held_p     = io_output_payload;
        held_l     = io_output_last;
        if (io_input_valid && io_input_ready) begin
            in_hs_seen = 1;
            push_word(io_input_payload, io_input_last);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_mode) io_output_ready = stall_pat[cyc % 4];
    endtask

    task automatic send(input logic [255:0] w, input logic last);
        bit ok;
        ok = 0;
        io_input_valid   = 1'b1;
        io_input_payload = w;
        io_input_last    = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = in_hs_seen;
        end
        io_input_valid = 1'b0;
        io_input_last  = 1'b0;
        if (!ok) chk("send_timeout", 256'(ok), 256'd1);
    endtask

    task automatic drain();
        stall_mode      = 0;
        io_output_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || io_output_valid); i++) tick();
        chk("drain_empty", 256'(sb.size()), 256'd0);
        chk("drain_valid", 256'(io_output_valid), 256'd0);
    endtask

    task automatic do_reset();
        io_input_valid  = 1'b0;
        io_input_last   = 1'b0;
        stall_mode      = 0;
        io_output_ready = 1'b1;
        resetn          = 1'b0;
        #1;
        chk("rst_valid", 256'(io_output_valid), 256'd0);
        chk("rst_last", 256'(io_output_last), 256'd0);
        chk("rst_payload", 256'(io_output_payload), 256'd0);
        chk("rst_frames", 256'(frames_out), 256'd0);
        chk("rst_reduced", 256'(reduced_cnt), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        sb.delete();
        model_idx  = 0;
        prev_stall = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(io_input_ready), 256'd1);
    endtask

    initial begin
        #2;
        do_reset();

        // Full frame, no padding, one-cycle latency.
        send(256'd1, 1'b0);
        chk("lat1_valid", 256'(io_output_valid), 256'd1);
        chk("lat1_payload", 256'(io_output_payload), 256'd1);
        chk("lat1_last", 256'(io_output_last), 256'd0);
        send(256'd2, 1'b0);
        chk("lat2_payload", 256'(io_output_payload), 256'd2);
        send(256'd3, 1'b1);
        chk("lat3_payload", 256'(io_output_payload), 256'd3);
        chk("lat3_last", 256'(io_output_last), 256'd1);
        drain();
        chk("t1_frames", 256'(frames_out), 256'd1);

        // Short message padded with zeros.
        do_reset();
        send(256'd7, 1'b1);
        chk("pad_ready0", 256'(io_input_ready), 256'd0);
        tick();
        chk("pad_ready1", 256'(io_input_ready), 256'd0);
        tick();
        chk("pad_ready2", 256'(io_input_ready), 256'd1);
        drain();
        chk("t2_frames", 256'(frames_out), 256'd1);

        // Reduction boundaries.
        do_reset();
        send(MOD, 1'b0);
        send(MOD + 256'd5, 1'b0);
        send({1'b0, {255{1'b1}}}, 1'b1);
        drain();
        chk("t3_reduced", 256'(reduced_cnt), 256'd3);
        chk("t3_frames", 256'(frames_out), 256'd1);

        // Back-pressure pattern 1,0,0,1; bit 255 of the third word is ignored.
        do_reset();
        cyc        = 0;
        stall_mode = 1;
        send(256'd11, 1'b0);
        send(256'd12, 1'b0);
        send({1'b1, 255'd10}, 1'b0);
        send(256'd14, 1'b0);
        send(256'd15, 1'b0);
        send(256'd16, 1'b1);
        drain();
        chk("t4_frames", 256'(frames_out), 256'd2);
        chk("t4_reduced", 256'(reduced_cnt), 256'd0);

        // Reset mid-frame discards the partial frame.
        do_reset();
        send(256'd21, 1'b0);
        send(256'd22, 1'b0);
        do_reset();
        send(256'd9, 1'b0);
        send(256'd8, 1'b0);
        send(256'd7, 1'b1);
        drain();
        chk("t5_frames", 256'(frames_out), 256'd1);

        // NUM_FRAMES frames from a continuous source.
        do_reset();
        for (int i = 0; i < NUM_FRAMES * ARITY; i++) begin
            send(256'(i + 1), 1'b0);
        end
        chk("t6_frames_pre", 256'(frames_out), 256'(NUM_FRAMES - 1));
        chk("t6_done_pre", 256'(done), 256'd0);
        tick();
        chk("t6_frames", 256'(frames_out), 256'(NUM_FRAMES));
        chk("t6_done", 256'(done), 256'd1);
        chk("t6_ready_off", 256'(io_input_ready), 256'd0);
        io_input_valid   = 1'b1;
        io_input_payload = 256'd999;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_ready_stays", 256'(io_input_ready), 256'd0);
        chk("t6_no_output", 256'(io_output_valid), 256'd0);
        chk("t6_sb_empty", 256'(sb.size()), 256'd0);
        chk("t6_frames_hold", 256'(frames_out), 256'(NUM_FRAMES));
        io_input_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
